// File: rtl/demux_pkg.sv
// Shared types and helpers for the 4-bit 1:4 demux dispatcher.
// Channel indices wrap naturally because ch_idx_t is exactly CH_W bits wide.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 4;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic {
    MODE_EXPLICIT = 1'b0,
    MODE_RR       = 1'b1
  } disp_mode_t;

  // First free channel scanning ptr, ptr+1, ... (mod NUM_CH); ptr itself when none is free.
  // Scanning from the far end lets the nearest free channel overwrite the result last.
  function automatic ch_idx_t rr_pick(input logic [NUM_CH-1:0] free, input ch_idx_t ptr);
    ch_idx_t idx;
    rr_pick = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (free[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/demux_4bit.sv
// Combinational 4-bit 1:4 demultiplexer: data_in appears on the selected output,
// every other output is driven to zero.
module demux_4bit
  import demux_pkg::*;
(
  input  logic [CH_W-1:0]   sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3
);

  always_comb begin
    y0 = '0;
    y1 = '0;
    y2 = '0;
    y3 = '0;
    case (sel)
      2'd0:    y0 = data_in;
      2'd1:    y1 = data_in;
      2'd2:    y2 = data_in;
      default: y3 = data_in;
    endcase
  end

endmodule

// File: rtl/demux_dispatcher.sv
// Routes a valid/ready 4-bit stream into four one-entry output slots, either by
// explicit destination or round-robin, and counts accepted beats.
//
// Handshake: a beat moves when valid && ready are both high at a rising edge.
// Ready never depends on the same port's valid; a slot being drained this cycle
// counts as free, so a channel can sustain one beat per cycle.
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter bit RR_SKIP_FULL = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_dest,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          sel_o,
  output logic [CNT_W-1:0]         accept_cnt
);

  logic [NUM_CH-1:0]              r_slot_valid;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_slot_data;
  ch_idx_t                        r_rr_ptr;
  logic [CNT_W-1:0]               r_accept_cnt;

  disp_mode_t                     w_mode;
  logic [NUM_CH-1:0]              w_free;
  ch_idx_t                        w_target;
  logic                           w_ready;
  logic                           w_accept;
  logic [NUM_CH-1:0][DATA_W-1:0]  w_load;

  assign w_mode = disp_mode_t'(mode);
  assign w_free = ~r_slot_valid | out_ready;

  always_comb begin
    w_target = r_rr_ptr;
    if (w_mode == MODE_EXPLICIT) begin
      w_target = in_dest;
    end else if (RR_SKIP_FULL) begin
      w_target = rr_pick(w_free, r_rr_ptr);
    end
  end

  // rst_n gates ready directly so nothing is offered while reset is held.
  assign w_ready  = rst_n && en && w_free[w_target];
  assign w_accept = in_valid && w_ready;

  demux_4bit u_demux (
    .sel     (w_target),
    .data_in (in_data),
    .y0      (w_load[0]),
    .y1      (w_load[1]),
    .y2      (w_load[2]),
    .y3      (w_load[3])
  );

  // Reload wins over drain so a simultaneous drain/reload keeps the slot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_valid <= '0;
      r_slot_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_accept && (w_target == ch_idx_t'(i))) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_data[i]  <= w_load[i];
        end else if (r_slot_valid[i] && out_ready[i]) begin
          r_slot_valid[i] <= 1'b0;
          r_slot_data[i]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_accept_cnt <= '0;
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      if (w_mode == MODE_RR) begin
        r_rr_ptr <= w_target + ch_idx_t'(1);
      end
    end
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_slot_valid;
  assign out_data   = r_slot_data;
  assign sel_o      = w_target;
  assign accept_cnt = r_accept_cnt;

endmodule
